// File: rtl/peak_scan_pkg.sv
// Shared types and widths for the line peak-scan controller.
// Imported by the controller and by anything sitting beside it.
package peak_scan_pkg;

  localparam int unsigned POS_W  = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDLE_W = 16;

  localparam int unsigned PIXEL_COUNT_DEF = 512;
  localparam int unsigned TIMEOUT_DEF     = 1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_SETTLE,
    S_HOLD
  } state_e;

endpackage

// File: rtl/peak_scan_ctrl.sv
// Line scan sequencer: clears the external peak finder, streams one line
// of pixels into it, then latches and holds the peak result.
module peak_scan_ctrl
  import peak_scan_pkg::*;
#(
  parameter int unsigned PIXEL_COUNT = PIXEL_COUNT_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              trig,
  input  logic [DATA_W-1:0] threshold,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              mf_start,
  output logic              mf_valid,
  output logic [DATA_W-1:0] mf_data,
  output logic [POS_W-1:0]  mf_pos,
  input  logic [POS_W-1:0]  mf_max_pos,
  input  logic [DATA_W-1:0] mf_max_value,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [POS_W-1:0]  res_pos,
  output logic [DATA_W-1:0] res_value,
  output logic              res_found,
  output logic              res_timeout,
  output logic [7:0]        trig_miss
);

  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(PIXEL_COUNT - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [POS_W-1:0]    cnt_q, cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                abort_q, abort_d;
  logic [DATA_W-1:0]   thr_q, thr_d;
  logic [7:0]          miss_q, miss_d;
  logic [POS_W-1:0]    rpos_q, rpos_d;
  logic [DATA_W-1:0]   rval_q, rval_d;
  logic                rfound_q, rfound_d;
  logic                rto_q, rto_d;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idle_q   <= '0;
      abort_q  <= 1'b0;
      thr_q    <= '0;
      miss_q   <= '0;
      rpos_q   <= '0;
      rval_q   <= '0;
      rfound_q <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      abort_q  <= abort_d;
      thr_q    <= thr_d;
      miss_q   <= miss_d;
      rpos_q   <= rpos_d;
      rval_q   <= rval_d;
      rfound_q <= rfound_d;
      rto_q    <= rto_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    abort_d  = abort_q;
    thr_d    = thr_q;
    miss_d   = miss_q;
    rpos_d   = rpos_q;
    rval_d   = rval_q;
    rfound_d = rfound_q;
    rto_d    = rto_q;
    mf_start = 1'b0;
    mf_valid = 1'b0;
    mf_data  = '0;
    mf_pos   = '0;

    // Any trigger outside IDLE is lost; count it, pinned at 255.
    if (trig && state_q != S_IDLE && miss_q != 8'hFF)
      miss_d = miss_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          thr_d   = threshold;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mf_start = 1'b1;
        cnt_d    = '0;
        idle_d   = '0;
        state_d  = S_SCAN;
      end
      S_SCAN: begin
        mf_valid = pix_valid;
        mf_data  = pix_data;
        mf_pos   = cnt_q;
        if (pix_valid) begin
          idle_d = '0;
          if (cnt_q == LAST_POS)
            state_d = S_SETTLE;
          else
            cnt_d = cnt_q + POS_W'(1);
        end else if (idle_q == IDLE_LIM) begin
          abort_d = 1'b1;
          state_d = S_SETTLE;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      S_SETTLE: begin
        rpos_d   = mf_max_pos;
        rval_d   = mf_max_value;
        rto_d    = abort_q;
        rfound_d = (mf_max_value >= thr_q) &&
                   (mf_max_value != '0) && !abort_q;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          abort_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign res_valid   = (state_q == S_HOLD);
  assign res_pos     = rpos_q;
  assign res_value   = rval_q;
  assign res_found   = rfound_q;
  assign res_timeout = rto_q;
  assign trig_miss   = miss_q;

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Bench for peak_scan_ctrl: behavioural line model, a stand-in peak
// finder, directed scenarios and randomized lines.
module tb_peak_scan_ctrl;
  import peak_scan_pkg::*;

  localparam int PC = 512;
  localparam int TO = 20;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [7:0] threshold = '0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       res_ready = 1'b0;
  logic       mf_start, mf_valid, busy, res_valid;
  logic [7:0] mf_data, res_value, trig_miss;
  logic [8:0] mf_pos, res_pos;
  logic       res_found, res_timeout;
  logic [8:0] pf_pos = '0;
  logic [7:0] pf_val = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_px = 0, rv_rise = 0, starts = 0;
  bit rv_prev = 0;
  bit stray = 0;
  int px[PC];

  always #5 clk_in = ~clk_in;

  peak_scan_ctrl #(.PIXEL_COUNT(PC), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst(rst), .trig(trig), .threshold(threshold),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .mf_start(mf_start), .mf_valid(mf_valid), .mf_data(mf_data),
    .mf_pos(mf_pos), .mf_max_pos(pf_pos), .mf_max_value(pf_val),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_pos(res_pos), .res_value(res_value), .res_found(res_found),
    .res_timeout(res_timeout), .trig_miss(trig_miss)
  );

  // Stand-in peak finder living beside the controller.
  always @(posedge clk_in) begin
    if (rst || mf_start) begin
      pf_pos <= '0;
      pf_val <= '0;
    end else if (mf_valid && mf_data > pf_val) begin
      pf_val <= mf_data;
      pf_pos <= mf_pos;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle,1 clear,2 scan,3 settle,4 hold.
  int m_ph = 0, m_cnt = 0, m_idle = 0, m_abort = 0, m_thr = 0;
  int m_miss = 0, m_mx = 0, m_mxp = 0;
  int m_rpos = 0, m_rval = 0, m_rfound = 0, m_rto = 0;

  always @(posedge clk_in) begin
    cyc++;
    if (rst) begin
      m_ph = 0; m_cnt = 0; m_idle = 0; m_abort = 0; m_thr = 0;
      m_miss = 0; m_mx = 0; m_mxp = 0;
      m_rpos = 0; m_rval = 0; m_rfound = 0; m_rto = 0;
    end else begin
      if (trig && m_ph != 0 && m_miss < 255) m_miss++;
      case (m_ph)
        0: if (trig) begin m_thr = int'(threshold); m_ph = 1; end
        1: begin
          m_cnt = 0; m_idle = 0; m_mx = 0; m_mxp = 0; m_ph = 2;
        end
        2: if (pix_valid) begin
          if (int'(pix_data) > m_mx) begin
            m_mx = int'(pix_data);
            m_mxp = m_cnt;
          end
          m_idle = 0;
          if (m_cnt == PC - 1) m_ph = 3;
          else m_cnt++;
        end else begin
          m_idle++;
          if (m_idle == TO) begin m_abort = 1; m_ph = 3; end
        end
        3: begin
          m_rpos = m_mxp; m_rval = m_mx; m_rto = m_abort;
          m_rfound = (!m_abort && m_mx >= m_thr && m_mx != 0) ? 1 : 0;
          m_ph = 4;
        end
        default: if (res_ready) begin m_ph = 0; m_abort = 0; end
      endcase
    end
  end

  always @(negedge clk_in) begin
    if (cyc > 0) begin
      chk("busy", int'(busy), (m_ph != 0) ? 1 : 0);
      chk("mf_start", int'(mf_start), (m_ph == 1) ? 1 : 0);
      chk("mf_valid", int'(mf_valid), (m_ph == 2 && pix_valid) ? 1 : 0);
      chk("mf_data", int'(mf_data), (m_ph == 2) ? int'(pix_data) : 0);
      chk("mf_pos", int'(mf_pos), (m_ph == 2) ? m_cnt : 0);
      chk("res_valid", int'(res_valid), (m_ph == 4) ? 1 : 0);
      chk("res_pos", int'(res_pos), m_rpos);
      chk("res_value", int'(res_value), m_rval);
      chk("res_found", int'(res_found), m_rfound);
      chk("res_timeout", int'(res_timeout), m_rto);
      chk("trig_miss", int'(trig_miss), m_miss);
    end
    if (mf_valid) last_px = cyc;
    if (mf_start) starts++;
    if (res_valid && !rv_prev) rv_rise = cyc;
    rv_prev = res_valid;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_line(input int thr, input bit junk);
    trig = 1'b1;
    threshold = 8'(thr);
    pix_valid = junk;
    pix_data = 8'hEE;
    #1;
    if (junk) chk("idle_mf_valid", int'(mf_valid), 0);
    tick();
    trig = junk;
    threshold = 8'($urandom);
    #1;
    if (junk) chk("clear_mf_valid", int'(mf_valid), 0);
    tick();
    trig = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic send(input int lo, input int hi, input int gapmax);
    for (int i = lo; i < hi; i++) begin
      repeat ($urandom_range(0, gapmax)) begin
        pix_data = 8'($urandom);
        trig = stray && ($urandom_range(0, 3) == 0);
        tick();
        trig = 1'b0;
      end
      pix_valid = 1'b1;
      pix_data = 8'(px[i]);
      tick();
      pix_valid = 1'b0;
    end
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    if (!res_valid) chk("res_valid_wait", 0, 1);
    @(negedge clk_in);
    #1;
  endtask

  task automatic finish_line(input int hold);
    repeat (hold) tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic fill_std();
    for (int i = 0; i < PC; i++) px[i] = 10;
    px[100] = 200;
  endtask

  int s0;
  int n;
  int thr;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_trig_miss", int'(trig_miss), 0);

    fill_std();
    s0 = starts;
    start_line(50, 0);
    send(0, PC, 0);
    wait_res();
    chk("l1_starts", starts - s0, 1);
    chk("l1_latency", rv_rise - last_px, 2);
    chk("l1_pos", int'(res_pos), 100);
    chk("l1_value", int'(res_value), 200);
    chk("l1_found", int'(res_found), 1);
    chk("l1_timeout", int'(res_timeout), 0);
    finish_line(2);

    start_line(250, 0);
    send(0, PC, 1);
    wait_res();
    chk("l2_found", int'(res_found), 0);
    chk("l2_value", int'(res_value), 200);
    finish_line(0);

    start_line(50, 0);
    send(0, 301, 0);
    wait_res();
    chk("l3_latency", rv_rise - last_px, TO + 2);
    chk("l3_timeout", int'(res_timeout), 1);
    chk("l3_found", int'(res_found), 0);
    finish_line(1);
    chk("l3_idle", int'(busy), 0);

    start_line(50, 0);
    send(0, PC, 0);
    wait_res();
    repeat (300) begin
      trig = 1'b1;
      tick();
      trig = 1'b0;
      tick();
    end
    chk("l4_trig_miss", int'(trig_miss), 255);
    chk("l4_res_valid", int'(res_valid), 1);
    chk("l4_pos", int'(res_pos), 100);
    chk("l4_found", int'(res_found), 1);
    trig = 1'b1;
    finish_line(0);
    trig = 1'b0;

    start_line(50, 0);
    send(0, 250, 0);
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'(px[250]);
    trig = 1'b1;
    res_ready = 1'b1;
    tick();
    rst = 1'b0;
    pix_valid = 1'b0;
    trig = 1'b0;
    res_ready = 1'b0;
    #1;
    chk("r_busy", int'(busy), 0);
    chk("r_res_valid", int'(res_valid), 0);
    chk("r_mf_pos", int'(mf_pos), 0);
    chk("r_res_pos", int'(res_pos), 0);
    chk("r_res_value", int'(res_value), 0);
    chk("r_trig_miss", int'(trig_miss), 0);

    start_line(50, 1);
    pix_valid = 1'b1;
    pix_data = 8'(px[0]);
    #1;
    chk("first_mf_pos", int'(mf_pos), 0);
    chk("first_mf_valid", int'(mf_valid), 1);
    tick();
    pix_valid = 1'b0;
    send(1, PC, 0);
    wait_res();
    chk("l5_pos", int'(res_pos), 100);
    finish_line(0);

    for (int i = 0; i < PC; i++) px[i] = 0;
    start_line(0, 0);
    send(0, PC, 0);
    wait_res();
    chk("zero_found", int'(res_found), 0);
    finish_line(0);

    stray = 1;
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < PC; i++) px[i] = int'($urandom_range(0, 255));
      thr = int'($urandom_range(0, 255));
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(9, 511)) : PC;
      start_line(thr, 1'($urandom_range(0, 1)));
      send(0, n, int'($urandom_range(0, 3)));
      wait_res();
      finish_line(int'($urandom_range(0, 5)));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog cyc=%0d got=running expected=done", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/peak_scan_ctrl.md
PEAK_SCAN_CTRL -- requirements
Module: peak_scan_ctrl

Interface
REQ-001 Parameter PIXEL_COUNT, 512, pixels per line; legal range 9..512.
REQ-002 Parameter TIMEOUT, 1000, maximum idle cycles between pixels in SCAN; legal range 1..65535.
REQ-003 clk_in  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 trig  in  1  line-start request, single-cycle pulse.
REQ-006 threshold  in  8  minimum peak value for a valid hit, sampled on accepted trig.
REQ-007 pix_valid  in  1  pixel sample strobe.
REQ-008 pix_data  in  8  pixel amplitude.
REQ-009 mf_start  out  1  clear pulse to peak finder.
REQ-010 mf_valid  out  1  forwarded pixel strobe.
REQ-011 mf_data  out  8  forwarded pixel amplitude.
REQ-012 mf_pos  out  9  pixel index of forwarded sample.
REQ-013 mf_max_pos  in  9  peak position from peak finder.
REQ-014 mf_max_value  in  8  peak value from peak finder.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 res_valid, res_ready  out/in  1 each  result handshake.
REQ-017 res_pos  out  9; res_value  out  8; res_found  out  1; res_timeout  out  1 -- line result fields.
REQ-018 trig_miss  out  8  saturating count of triggers dropped while busy.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, SCAN, SETTLE, HOLD.
REQ-020 IDLE: trig=1 -> CLEAR, latch threshold; otherwise remain.
REQ-021 CLEAR: mf_start=1 for exactly this cycle, pixel counter := 0, unconditional -> SCAN; pix_valid in CLEAR dropped.
REQ-022 SCAN: mf_valid = pix_valid, mf_data = pix_data, mf_pos = counter, combinationally; counter increments per accepted pixel.
REQ-023 SCAN: pixel accepted with counter == PIXEL_COUNT-1 -> SETTLE.
REQ-024 SCAN: idle counter resets on each accepted pixel; reaching TIMEOUT consecutive idle cycles -> SETTLE with abort flag set.
REQ-025 mf_valid, mf_data, mf_pos SHALL be 0 outside SCAN.
REQ-026 SETTLE: latch res_pos = mf_max_pos, res_value = mf_max_value, res_timeout = abort flag, res_found = (mf_max_value >= threshold) and (mf_max_value != 0) and not abort -> HOLD.
REQ-027 Latency: last pixel accepted in cycle N -> res_valid=1 in cycle N+2.
REQ-028 HOLD: res_valid=1, fields stable; res_valid & res_ready -> IDLE in next cycle, abort flag cleared.
REQ-029 res_* fields SHALL retain last line's values after handshake until next SETTLE.
REQ-030 trig while busy=1 (including the HOLD handshake cycle) SHALL be ignored and increment trig_miss, saturating at 255.
REQ-031 Counter width 9 bits; no wrap possible since PIXEL_COUNT <= 512; idle counter 16 bits.

Reset
REQ-032 rst=1 at any state -> IDLE next cycle; busy, res_valid, mf_start, mf_valid, mf_data, mf_pos, res_pos, res_value, res_found, res_timeout, trig_miss, counters, abort flag, latched threshold all 0.
REQ-033 Reset SHALL take priority over trig, pix_valid and res_ready in the same cycle.

Structure
REQ-034 Package peak_scan_pkg SHALL hold the state enum, PIXEL_COUNT/TIMEOUT defaults, and POS_W=9, DATA_W=8 width constants.
REQ-035 No sub-module; the peak finder SHALL be instantiated beside this block at the parent level, not inside it.

Verification
REQ-036 Reset, trig, 512 pixels with value 200 at index 100, others 10, threshold 50 -> mf_start one cycle, res_valid 2 cycles after last pixel, res_pos=100, res_value=200, res_found=1, res_timeout=0.
REQ-037 Same line, threshold 250 -> res_found=0, res_value=200.
REQ-038 Stop pixels after index 300, TIMEOUT=20 -> res_valid after 20 idle cycles + 1, res_timeout=1, res_found=0.
REQ-039 300 trig pulses while busy, res_ready held 0 -> trig_miss=255, res_valid stays 1 and fields stable.
REQ-040 rst asserted mid-SCAN at pixel 250 -> next cycle all outputs 0, busy=0; new trig starts clean line with mf_pos from 0.
REQ-041 pix_valid and trig in IDLE and CLEAR -> mf_valid stays 0 during IDLE and CLEAR; first forwarded mf_pos=0 in SCAN.
